interconnect_matrix: RTL and testbench
======================================

Name: interconnect_matrix

Overview:
- Parametrised successor to the single-output CLB interconnect selector.
- Routes N_SRC candidate signals to N_OUT LUT inputs: pad inputs I*, local Q*, remote RQ*, carry CYO*.
- Per-output select fields are loaded serially through a daisy-chainable configuration scan chain while prgm_b=0, committed atomically when prgm_b rises, and applied in user mode.
- Adds length checking, out-of-range detection (drives 0, never x), and optional output registering.

Parameters:
- N_SRC, 40, number of routable sources; src bit index = select code.
- N_OUT, 4, number of routed outputs (LUT inputs).
- SEL_W, 6, select field width; must satisfy 2**SEL_W >= N_SRC.
- REG_OUT, 1, 1 = registered outputs (1-cycle latency); 0 = combinational.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- prgm_b  in  1  0 = programming mode, 1 = user mode.
- cfg_en  in  1  shift enable for the scan chain; honoured only while prgm_b=0.
- cfg_sin  in  1  serial config bit in.
- cfg_sout  out  1  serial config bit out, to the next block in the chain.
- cfg_done  out  1  valid configuration active.
- cfg_err  out  1  last programming attempt was short (sticky until next LOAD entry).
- src  in  N_SRC  routable sources.
- route_out  out  N_OUT  routed values.
- sel_err  out  N_OUT  per-output select code >= N_SRC.

Behaviour:
- CFG_BITS = N_OUT*SEL_W (24 by default).
- Reset (rst_b=0, asynchronous):
  - State UNCFG.
  - Shift register sr, active config act_cfg and bit counter bit_cnt all cleared.
  - All outputs 0.
- FSM states: UNCFG, LOAD, RUN.
  - UNCFG → LOAD when prgm_b=0. Entering LOAD clears bit_cnt and cfg_err, and deasserts cfg_done.
  - RUN → LOAD when prgm_b=0.
  - LOAD shifting: each clk with cfg_en=1 does sr <= {cfg_sin, sr[CFG_BITS-1:1]}.
    - bit_cnt increments and saturates at CFG_BITS.
    - cfg_sout = sr[0], continuously.
  - LOAD exit on the edge where prgm_b=1 is sampled:
    - If bit_cnt==CFG_BITS: act_cfg <= sr; state RUN; cfg_done=1 from that edge.
    - Otherwise: cfg_err=1; state UNCFG; act_cfg is not modified; cfg_done stays 0.
  - More than CFG_BITS shifts is legal (daisy chain). Excess bits pass out on cfg_sout; the last CFG_BITS bits are retained.
- Field layout:
  - Output k uses act_cfg[k*SEL_W +: SEL_W].
  - The first bit shifted in ends up at sr[0], i.e. it is output 0's select LSB.
- Routing in RUN:
  - route_out[k] = src[sel_k] if sel_k < N_SRC; else 0, with sel_err[k]=1.
  - REG_OUT=1: route_out and sel_err are registered, so a src change is visible 1 clk later.
  - REG_OUT=0: route_out and sel_err are combinational.
- Outside RUN: route_out=0 and sel_err=0.
  - Gated by the registered state, so outputs go 0 from the edge that enters LOAD.
  - The output register is also cleared on that edge.
- cfg_en with prgm_b=1 is ignored: sr and bit_cnt hold.
- Reset mid-LOAD discards partial data. No x is ever driven.

Decomposition:
- Package icu_pkg holds:
  - state enum (UNCFG/LOAD/RUN);
  - clog2 function;
  - CFG_BITS derivation function;
  - source-group base constants: IDX_I=0, IDX_Q=16, IDX_RQ=24, IDX_CYO=32.
- One sub-module, route_mux_cell: an N_SRC:1 mux with range check producing a value and a sel_err bit. It is instantiated N_OUT times; FSM, chain and output registers stay in the top module.

Test Plan (defaults, REG_OUT=1):
- Reset: assert rst_b=0 mid-clock → route_out=0, sel_err=0, cfg_done=0, cfg_err=0, cfg_sout=0 immediately.
- Full load:
  - Stimulus: shift 24 bits encoding sel0=0, sel1=15, sel2=39, sel3=17, then raise prgm_b.
  - Config response: cfg_done=1.
  - Routing response: src=1<<15 → route_out=4'b0010 one clk later; src=1<<39 → 4'b0100.
- Short load: shift 20 bits, raise prgm_b → cfg_err=1, cfg_done=0, route_out=0, previous act_cfg unchanged.
- Out-of-range: load sel2=45 with the others valid, src all-ones → route_out=4'b1011, sel_err=4'b0100.
- Daisy chain: shift 48 bits → first bit in appears on cfg_sout after shift 24; act_cfg equals the last 24 bits.
- Reprogram/reset mid-operation:
  - From RUN, drop prgm_b → route_out=0 at the next edge.
  - After 10 shifts, pulse rst_b → bit_cnt=0, state UNCFG, and a following 24-bit load succeeds.

Source files
------------

// File: rtl/icu_pkg.sv
// Shared types and constants for the CLB interconnect matrix: FSM state encoding,
// width helpers and the base indices of each source group on the src bus.
package icu_pkg;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } icu_state_e;

    // Source group bases: pad inputs, local Q, remote RQ, carry outputs.
    localparam int IDX_I   = 0;
    localparam int IDX_Q   = 16;
    localparam int IDX_RQ  = 24;
    localparam int IDX_CYO = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cfg_bits(input int n_out, input int sel_w);
        return n_out * sel_w;
    endfunction

endpackage

// File: rtl/route_mux_cell.sv
// One routed output: N_SRC:1 selector that drives 0 and flags an error when the
// select code does not name an existing source.
module route_mux_cell
    import icu_pkg::*;
#(
    parameter int N_SRC = 40,
    parameter int SEL_W = 6
) (
    input  logic [N_SRC-1:0] src_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             val_o,
    output logic             err_o
);

    localparam logic [SEL_W:0] N_SRC_L = (SEL_W + 1)'(N_SRC);

    always_comb begin
        val_o = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_i == i[SEL_W-1:0]) begin
                val_o = src_i[i];
            end
        end
    end

    assign err_o = ({1'b0, sel_i} >= N_SRC_L);

endmodule

// File: rtl/interconnect_matrix.sv
// Scan-chain programmed interconnect matrix: routes N_SRC sources onto N_OUT LUT
// inputs using per-output select fields committed atomically on leaving programming mode.
module interconnect_matrix
    import icu_pkg::*;
#(
    parameter  int N_SRC   = 40,
    parameter  int N_OUT   = 4,
    parameter  int SEL_W   = 6,
    parameter  int REG_OUT = 1,
    localparam int CNT_W   = icu_pkg::clog2(N_OUT * SEL_W + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             prgm_b,
    input  logic             cfg_en,
    input  logic             cfg_sin,
    output logic             cfg_sout,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic [N_SRC-1:0] src,
    output logic [N_OUT-1:0] route_out,
    output logic [N_OUT-1:0] sel_err,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_bit_cnt
);

    localparam int              CFG_BITS = cfg_bits(N_OUT, SEL_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    icu_state_e            state_q, state_d;
    logic [CFG_BITS-1:0]   sr_q, sr_d;
    logic [CFG_BITS-1:0]   act_cfg_q, act_cfg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  cfg_done_q, cfg_done_d;
    logic [N_OUT-1:0]      mux_val, mux_err;
    logic                  run_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_UNCFG;
            sr_q       <= '0;
            act_cfg_q  <= '0;
            bit_cnt_q  <= '0;
            cfg_err_q  <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            act_cfg_q  <= act_cfg_d;
            bit_cnt_q  <= bit_cnt_d;
            cfg_err_q  <= cfg_err_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        act_cfg_d  = act_cfg_q;
        bit_cnt_d  = bit_cnt_q;
        cfg_err_d  = cfg_err_q;
        cfg_done_d = cfg_done_q;
        case (state_q)
            ST_UNCFG, ST_RUN: begin
                if (!prgm_b) begin
                    state_d    = ST_LOAD;
                    bit_cnt_d  = '0;
                    cfg_err_d  = 1'b0;
                    cfg_done_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (prgm_b) begin
                    // A short load leaves the previous active config untouched.
                    if (bit_cnt_q == CNT_FULL) begin
                        act_cfg_d  = sr_q;
                        state_d    = ST_RUN;
                        cfg_done_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_UNCFG;
                    end
                end else if (cfg_en) begin
                    sr_d = {cfg_sin, sr_q[CFG_BITS-1:1]};
                    if (bit_cnt_q != CNT_FULL) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_UNCFG;
        endcase
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_cell
        route_mux_cell #(
            .N_SRC(N_SRC),
            .SEL_W(SEL_W)
        ) u_cell (
            .src_i(src),
            .sel_i(act_cfg_q[k*SEL_W +: SEL_W]),
            .val_o(mux_val[k]),
            .err_o(mux_err[k])
        );
    end

    assign run_q = (state_q == ST_RUN);

    if (REG_OUT != 0) begin : g_reg_out
        logic [N_OUT-1:0] route_q, err_q;

        // Cleared on any edge that leaves or has not yet settled into RUN.
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                route_q <= '0;
                err_q   <= '0;
            end else if (run_q && (state_d == ST_RUN)) begin
                route_q <= mux_val;
                err_q   <= mux_err;
            end else begin
                route_q <= '0;
                err_q   <= '0;
            end
        end

        assign route_out = run_q ? route_q : '0;
        assign sel_err   = run_q ? err_q   : '0;
    end else begin : g_comb_out
        assign route_out = run_q ? mux_val : '0;
        assign sel_err   = run_q ? mux_err : '0;
    end

    assign cfg_sout    = sr_q[0];
    assign cfg_done    = cfg_done_q;
    assign cfg_err     = cfg_err_q;
    assign dbg_state   = state_q;
    assign dbg_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_interconnect_matrix.sv
// Directed bench for interconnect_matrix with default parameters (REG_OUT=1):
// reset, full/short/out-of-range loads, daisy-chain pass-through and mid-load reset.
module tb_interconnect_matrix;
    import icu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        prgm_b;
    logic        cfg_en;
    logic        cfg_sin;
    logic        cfg_sout;
    logic        cfg_done;
    logic        cfg_err;
    logic [39:0] src;
    logic [3:0]  route_out;
    logic [3:0]  sel_err;
    logic [1:0]  dbg_state;
    logic [4:0]  dbg_bit_cnt;

    int checks = 0;
    int errors = 0;

    logic [23:0] word_a, word_b;
    logic [47:0] seq;

    always #5 clk = ~clk;

    interconnect_matrix #(
        .N_SRC(40), .N_OUT(4), .SEL_W(6), .REG_OUT(1)
    ) dut (
        .clk(clk), .rst_b(rst_b), .prgm_b(prgm_b), .cfg_en(cfg_en),
        .cfg_sin(cfg_sin), .cfg_sout(cfg_sout), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .src(src), .route_out(route_out), .sel_err(sel_err),
        .dbg_state(dbg_state), .dbg_bit_cnt(dbg_bit_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [47:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_en  = 1'b1;
            cfg_sin = w[i];
            tick();
        end
        cfg_en  = 1'b0;
        cfg_sin = 1'b0;
    endtask

    function automatic logic [23:0] pack(input int s0, input int s1, input int s2, input int s3);
        return {s3[5:0], s2[5:0], s1[5:0], s0[5:0]};
    endfunction

    initial begin
        rst_b   = 1'b1;
        prgm_b  = 1'b1;
        cfg_en  = 1'b0;
        cfg_sin = 1'b0;
        src     = '0;

        // Asynchronous reset mid-clock
        #13 rst_b = 1'b0;
        #1;
        check("rst_route", route_out, 4'b0000);
        check("rst_selerr", sel_err, 4'b0000);
        check("rst_done", cfg_done, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_sout", cfg_sout, 1'b0);
        check("rst_state", dbg_state, ST_UNCFG);
        check("rst_cnt", dbg_bit_cnt, 5'd0);
        #3 rst_b = 1'b1;
        tick();
        check("idle_state", dbg_state, ST_UNCFG);

        // Full load: sel0=0 sel1=15 sel2=39 sel3=17
        prgm_b = 1'b0;
        tick();
        check("load_state", dbg_state, ST_LOAD);
        shift_bits({24'd0, pack(0, 15, 39, 17)}, 24);
        check("full_cnt", dbg_bit_cnt, 5'd24);
        prgm_b = 1'b1;
        tick();
        check("full_done", cfg_done, 1'b1);
        check("full_err", cfg_err, 1'b0);
        check("full_state", dbg_state, ST_RUN);
        src = 40'd1 << 15;
        #1;
        check("full_latency", route_out, 4'b0000);
        tick();
        check("full_src15", route_out, 4'b0010);
        check("full_selerr", sel_err, 4'b0000);
        src = 40'd1 << 39;
        #1;
        check("full_hold", route_out, 4'b0010);
        tick();
        check("full_src39", route_out, 4'b0100);
        src = 40'd1 << (IDX_Q + 1);
        tick();
        check("full_src17", route_out, 4'b1000);
        src = 40'd1 << IDX_I;
        tick();
        check("full_src0", route_out, 4'b0001);
        src = '1;
        tick();
        check("full_ones", route_out, 4'b1111);

        // cfg_en in user mode must not touch the chain
        cfg_en  = 1'b1;
        cfg_sin = 1'b1;
        tick();
        tick();
        tick();
        cfg_en  = 1'b0;
        cfg_sin = 1'b0;
        check("user_cnt_hold", dbg_bit_cnt, 5'd24);
        check("user_sout_hold", cfg_sout, 1'b0);
        check("user_route", route_out, 4'b1111);

        // Short load of 20 bits
        prgm_b = 1'b0;
        tick();
        check("reprog_route0", route_out, 4'b0000);
        check("reprog_done0", cfg_done, 1'b0);
        shift_bits({24'd0, pack(1, 2, 3, 4)}, 20);
        check("short_cnt", dbg_bit_cnt, 5'd20);
        prgm_b = 1'b1;
        tick();
        check("short_err", cfg_err, 1'b1);
        check("short_done", cfg_done, 1'b0);
        check("short_route", route_out, 4'b0000);
        check("short_state", dbg_state, ST_UNCFG);
        prgm_b = 1'b0;
        tick();
        check("err_clear", cfg_err, 1'b0);

        // Out-of-range select on output 2
        shift_bits({24'd0, pack(0, 15, 45, 17)}, 24);
        prgm_b = 1'b1;
        tick();
        check("oor_done", cfg_done, 1'b1);
        src = '1;
        tick();
        check("oor_route", route_out, 4'b1011);
        check("oor_selerr", sel_err, 4'b0100);
        src = 40'd1 << 15;
        tick();
        check("oor_route15", route_out, 4'b0010);
        check("oor_selerr15", sel_err, 4'b0100);

        // Daisy chain: 48 shifts, first word passes through to cfg_sout
        word_a = pack(1, 15, 39, 17);
        word_b = pack(IDX_CYO, IDX_RQ, IDX_Q, IDX_I);
        seq    = {word_b, word_a};
        prgm_b = 1'b0;
        tick();
        check("daisy_route0", route_out, 4'b0000);
        for (int i = 0; i < 48; i++) begin
            cfg_en  = 1'b1;
            cfg_sin = seq[i];
            tick();
            if (i >= 23) begin
                check("daisy_sout", cfg_sout, seq[i-23]);
            end
        end
        cfg_en  = 1'b0;
        cfg_sin = 1'b0;
        check("daisy_cnt_sat", dbg_bit_cnt, 5'd24);
        prgm_b = 1'b1;
        tick();
        check("daisy_done", cfg_done, 1'b1);
        src = (40'd1 << IDX_CYO) | (40'd1 << IDX_Q);
        tick();
        check("daisy_route_a", route_out, 4'b0101);
        src = (40'd1 << IDX_RQ) | (40'd1 << IDX_I);
        tick();
        check("daisy_route_b", route_out, 4'b1010);
        src = '1;
        tick();
        check("daisy_ones", route_out, 4'b1111);

        // Drop prgm_b from RUN, then reset after 10 shifts
        prgm_b = 1'b0;
        tick();
        check("run2load_route", route_out, 4'b0000);
        check("run2load_selerr", sel_err, 4'b0000);
        check("run2load_state", dbg_state, ST_LOAD);
        shift_bits({24'd0, word_a}, 10);
        check("mid_cnt", dbg_bit_cnt, 5'd10);
        #2 rst_b = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, ST_UNCFG);
        check("mid_rst_cnt", dbg_bit_cnt, 5'd0);
        check("mid_rst_sout", cfg_sout, 1'b0);
        check("mid_rst_done", cfg_done, 1'b0);
        check("mid_rst_route", route_out, 4'b0000);
        #1 rst_b = 1'b1;
        tick();
        check("post_rst_state", dbg_state, ST_LOAD);
        shift_bits({24'd0, pack(0, 15, 39, 17)}, 24);
        prgm_b = 1'b1;
        tick();
        check("post_rst_done", cfg_done, 1'b1);
        check("post_rst_err", cfg_err, 1'b0);
        src = 40'd1 << 39;
        tick();
        check("post_rst_route", route_out, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
